// File: rtl/cam_reg_seq.sv
// cam_reg_seq: table-driven camera register sequencer feeding a byte-level I2C write master.
// Ports: clk/rst (sync, active high); start pulse runs the table from index 0.
//   tbl_idx/tbl_data : external table, {op,reg,val}, data valid one clk after tbl_idx.
//   i2c_req/i2c_rdy  : command handshake carrying i2c_dev/i2c_reg/i2c_wdata.
//   i2c_done/i2c_nack: transfer completion, nack qualifies done.
//   busy/done/err/err_idx : sequence status, done/err held until the next start.
module cam_reg_seq #(
  parameter int         RA_W       = 16,
  parameter int         IDX_W      = 9,
  parameter logic [7:0] DEV_ADDR   = 8'h78,
  parameter int         DELAY_UNIT = 25000,
  parameter int         MAX_RETRY  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [IDX_W-1:0]  tbl_idx,
  input  logic [RA_W+9:0]   tbl_data,
  output logic              i2c_req,
  input  logic              i2c_rdy,
  output logic [7:0]        i2c_dev,
  output logic [RA_W-1:0]   i2c_reg,
  output logic [7:0]        i2c_wdata,
  input  logic              i2c_done,
  input  logic              i2c_nack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [IDX_W-1:0]  err_idx
);
  localparam int CNT_W = $clog2(255 * DELAY_UNIT + 1);
  localparam int RT_W  = $clog2(MAX_RETRY + 2);
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DELAY, S_NEXT, S_DONE, S_ERROR
  } st_t;
  st_t              st_q;
  logic [IDX_W-1:0] idx_q, err_idx_q;
  logic [RT_W-1:0]  retry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [RA_W-1:0]  reg_q;
  logic [7:0]       wdata_q, dev_q;
  logic [1:0]       op;
  assign op        = tbl_data[RA_W+9:RA_W+8];
  assign tbl_idx   = idx_q;
  assign i2c_req   = st_q == S_ISSUE;
  assign i2c_dev   = dev_q;
  assign i2c_reg   = reg_q;
  assign i2c_wdata = wdata_q;
  assign busy      = !(st_q inside {S_IDLE, S_DONE, S_ERROR});
  assign done      = st_q == S_DONE;
  assign err       = st_q == S_ERROR;
  assign err_idx   = err_idx_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= S_IDLE;
      idx_q     <= '0;
      err_idx_q <= '0;
      retry_q   <= '0;
      cnt_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      dev_q     <= '0;
    end else begin
      case (st_q)
        S_IDLE, S_DONE, S_ERROR: if (start) begin
          idx_q   <= '0;
          retry_q <= '0;
          st_q    <= S_FETCH;
        end
        S_FETCH: st_q <= S_DECODE;
        S_DECODE: case (op)
          2'd0: begin
            dev_q   <= DEV_ADDR;
            reg_q   <= tbl_data[RA_W+7:8];
            wdata_q <= tbl_data[7:0];
            st_q    <= S_ISSUE;
          end
          2'd1: begin
            cnt_q <= CNT_W'(tbl_data[7:0]) * CNT_W'(DELAY_UNIT);
            st_q  <= S_DELAY;
          end
          2'd2: st_q <= S_DONE;
          default: begin
            err_idx_q <= idx_q;
            st_q      <= S_ERROR;
          end
        endcase
        S_ISSUE: if (i2c_rdy) st_q <= S_WAIT;
        S_WAIT: if (i2c_done) begin
          if (!i2c_nack) st_q <= S_NEXT;
          else if (retry_q < RT_W'(MAX_RETRY)) begin
            retry_q <= retry_q + RT_W'(1);
            st_q    <= S_ISSUE;
          end else begin
            err_idx_q <= idx_q;
            st_q      <= S_ERROR;
          end
        end
        S_DELAY: if (cnt_q == '0) st_q <= S_NEXT; else cnt_q <= cnt_q - CNT_W'(1);
        S_NEXT: begin
          retry_q <= '0;
          if (&idx_q) st_q <= S_DONE;
          else begin
            idx_q <= idx_q + IDX_W'(1);
            st_q  <= S_FETCH;
          end
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end
endmodule
